imem_pipe: RTL and testbench
============================

# imem_pipe

Parametrised, pipelined instruction memory for the fetch stage. It replaces the fixed-content, zero-latency instruction store with a word-addressed array that has:
- a programmable write (loader) port;
- a valid/ready request channel with backpressure;
- configurable read latency and fetch width;
- flush of in-flight fetches on redirect.

It sits between the PC generator and the decode stage.

## Interface
Parameters:
- DEPTH, 4096, memory size in 32-bit words; power of two, ≥ 16.
- LATENCY, 1, cycles from request accept to response valid; legal range 1..4.
- FETCH_WORDS, 1, consecutive instruction words returned per request; 1 or 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  fetch request valid.
- req_pc_i  in  32  byte address of the first instruction.
- req_ready_o  out  1  request can be accepted this cycle.
- flush_i  in  1  kill all in-flight and held responses.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  consumer accepts the response.
- rsp_pc_o  out  32  PC of the request that produced this response.
- rsp_instr_o  out  32*FETCH_WORDS  instruction words; word k is in bits [32k+31:32k].
- rsp_err_o  out  1  fetch fault.
- wr_en_i  in  1  loader write enable.
- wr_idx_i  in  $clog2(DEPTH)  loader word index.
- wr_data_i  in  32  loader write data.

## Operation
- Request accept: the request is accepted when req_valid_i && req_ready_o.
- Ready: req_ready_o = !stall || flush_i, where stall = rsp_valid_o && !rsp_ready_i.
- Array read at accept:
  - The array is read in the accept cycle at idx = (req_pc_i >> 2) mod DEPTH.
  - Word k of the fetch comes from (idx + k) mod DEPTH, so a fetch at the last index wraps to index 0.
- Pipeline:
  - The read result, the PC and the error bit enter a LATENCY-deep shift pipeline of valid-tagged stages.
  - The last stage drives the rsp_* outputs.
  - When not stalled, every stage advances each cycle; a bubble enters when no request is accepted.
  - When stalled, all stages hold, including the output.
- Flush:
  - flush_i clears the valid bit of every stage, including the output, at the next edge.
  - A request accepted in the same cycle as flush_i is kept: it enters stage 1 as the only valid entry.
  - Flush while the response is stalled drops the held response; no rsp_ready_i is needed.
- Loader writes:
  - A write with wr_en_i updates the array at the next edge.
  - A fetch accepted in the same cycle as a write to the same index returns the old data (read-before-write).
  - Writes are never blocked by stall or flush.
- Reset:
  - Pipeline valid bits, PC, instruction and error registers clear to 0.
  - Array contents are not reset and are undefined until loaded.
- Response order: responses are delivered in request order; no response is ever duplicated or reordered.

## Timing
- Reset values:
  - rsp_valid_o = 0, rsp_pc_o = 0, rsp_instr_o = 0, rsp_err_o = 0.
  - req_ready_o = 1 (not stalled).
- Latency: a request accepted at edge t, with no stall, appears on rsp_valid_o in the cycle after edge t+LATENCY−1. That is LATENCY cycles after the accept cycle.
- Throughput: one request per cycle with no stall.
- Stall behaviour:
  - A stall freezes the whole pipeline.
  - Up to LATENCY responses are held; none are lost.
- Handshake stability: while stalled, rsp_* outputs are stable until rsp_ready_i.
- Mid-operation reset: reset asserted mid-operation drops all in-flight responses immediately (asynchronously). The first post-reset accept behaves as above.

## Configuration
- IMEM_FAULT_CHECK_EN:
  - When defined, rsp_err_o = 1 for requests with req_pc_i[1:0] != 0, or with (req_pc_i >> 2) + FETCH_WORDS − 1 ≥ DEPTH. No wrap is applied for these requests.
  - Faulting responses carry rsp_instr_o = 0 and keep rsp_pc_o.
  - When undefined, rsp_err_o is tied to 0, req_pc_i[1:0] is ignored and indices wrap modulo DEPTH.

## Test plan
- Load via writes: idx0 = 0x123450B7, idx1 = 0x67808093. Then fetch PC 0x0 and 0x4 back-to-back with LATENCY = 2 and rsp_ready_i = 1 → responses 0x123450B7 then 0x67808093 on consecutive cycles, 2 cycles after each accept, with rsp_pc_o 0x0 and 0x4.
- Backpressure: issue 3 consecutive fetches and hold rsp_ready_i = 0 for 5 cycles → req_ready_o = 0 and the first response stays stable. After release, all 3 responses arrive in order with no loss or duplicates.
- Flush: with 2 fetches in flight, assert flush_i together with a new request to PC 0x8 → only the 0x8 response appears, LATENCY cycles later.
- Read-before-write: write idx3 = 0xDEADBEEF in the same cycle as a fetch of PC 0xC holding 0x32110113 → the response is 0x32110113. A following fetch of 0xC returns 0xDEADBEEF.
- FETCH_WORDS = 2, DEPTH = 16, fetch PC 0x3C:
  - macro undefined → words idx15 and idx0, rsp_err_o = 0;
  - macro defined → rsp_err_o = 1, data 0.
- Faults, macro defined: fetch PC 0x2 → rsp_err_o = 1, rsp_instr_o = 0. Then assert rstn_i low with requests in flight → rsp_valid_o = 0 immediately and all outputs at reset values.

Source files
------------

// File: rtl/imem_pipe.sv
// imem_pipe: loadable word-addressed instruction memory with a LATENCY-deep valid/ready fetch pipeline and flush.
// Define IMEM_FAULT_CHECK_EN to flag misaligned or out-of-range fetches instead of wrapping the index.
module imem_pipe #(
   parameter int DEPTH       = 4096,
   parameter int LATENCY     = 1,
   parameter int FETCH_WORDS = 1
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      req_valid_i,
   input  logic [31:0]               req_pc_i,
   output logic                      req_ready_o,
   input  logic                      flush_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [31:0]               rsp_pc_o,
   output logic [32*FETCH_WORDS-1:0] rsp_instr_o,
   output logic                      rsp_err_o,
   input  logic                      wr_en_i,
   input  logic [$clog2(DEPTH)-1:0]  wr_idx_i,
   input  logic [31:0]               wr_data_i
);
   localparam int AW = $clog2(DEPTH);
   localparam int IW = 32 * FETCH_WORDS;

   logic [31:0]        mem_q [DEPTH];
   logic [LATENCY-1:0] vld_q, vld_d, err_q, err_d;
   logic [31:0]        pc_q  [LATENCY];
   logic [31:0]        pc_d  [LATENCY];
   logic [IW-1:0]      ins_q [LATENCY];
   logic [IW-1:0]      ins_d [LATENCY];
   logic               stall, accept, fault;
   logic [AW-1:0]      idx;
   logic [IW-1:0]      rd_data;

   assign stall       = vld_q[LATENCY-1] && !rsp_ready_i;
   assign req_ready_o = !stall || flush_i;
   assign accept      = req_valid_i && req_ready_o;
   assign idx         = req_pc_i[AW+1:2];

`ifdef IMEM_FAULT_CHECK_EN
   assign fault = (req_pc_i[1:0] != 2'b00) ||
                  ({2'b00, req_pc_i[31:2]} + 32'(FETCH_WORDS - 1) >= 32'(DEPTH));
`else
   logic unused_pc;
   assign unused_pc = ^{req_pc_i[31:AW+2], req_pc_i[1:0]};
   assign fault     = 1'b0;
`endif

   // Word k wraps to the start of the array through AW-bit index overflow.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < FETCH_WORDS; k++)
         rd_data[32*k +: 32] = fault ? 32'h0 : mem_q[idx + AW'(k)];
   end

   always_ff @(posedge clk_i)
      if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;

   // A stall freezes every stage; flush only kills entries already in flight.
   always_comb begin
      vld_d = vld_q;
      err_d = err_q;
      pc_d  = pc_q;
      ins_d = ins_q;
      if (req_ready_o) begin
         vld_d[0] = accept;
         if (accept) begin
            pc_d[0]  = req_pc_i;
            ins_d[0] = rd_data;
            err_d[0] = fault;
         end
         for (int k = 1; k < LATENCY; k++) begin
            vld_d[k] = vld_q[k-1] && !flush_i;
            err_d[k] = err_q[k-1];
            pc_d[k]  = pc_q[k-1];
            ins_d[k] = ins_q[k-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
         vld_q <= '0;
         err_q <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            pc_q[k]  <= '0;
            ins_q[k] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         err_q <= err_d;
         pc_q  <= pc_d;
         ins_q <= ins_d;
      end

   assign rsp_valid_o = vld_q[LATENCY-1];
   assign rsp_err_o   = err_q[LATENCY-1];
   assign rsp_pc_o    = pc_q[LATENCY-1];
   assign rsp_instr_o = ins_q[LATENCY-1];
endmodule

// File: tb/tb_imem_pipe.sv
// tb_imem_pipe: scoreboard bench for imem_pipe (DEPTH=16, LATENCY=2, FETCH_WORDS=2).
// Expected fetches are queued on accept from a shadow copy of the array and compared on each handshake.
module tb_imem_pipe;
   localparam int DEPTH = 16;
   localparam int LAT   = 2;
   localparam int FW    = 2;
   localparam int AW    = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0]      pc;
      logic [32*FW-1:0] instr;
      logic             err;
   } rsp_t;

   logic              clk_i = 1'b0;
   logic              rstn_i = 1'b0;
   logic              req_valid_i = 1'b0;
   logic [31:0]       req_pc_i = '0;
   logic              req_ready_o;
   logic              flush_i = 1'b0;
   logic              rsp_valid_o;
   logic              rsp_ready_i = 1'b1;
   logic [31:0]       rsp_pc_o;
   logic [32*FW-1:0]  rsp_instr_o;
   logic              rsp_err_o;
   logic              wr_en_i = 1'b0;
   logic [AW-1:0]     wr_idx_i = '0;
   logic [31:0]       wr_data_i = '0;

   int          checks = 0;
   int          errors = 0;
   rsp_t        q[$];
   logic [31:0] mdl [DEPTH];

   imem_pipe #(.DEPTH(DEPTH), .LATENCY(LAT), .FETCH_WORDS(FW)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .req_valid_i(req_valid_i), .req_pc_i(req_pc_i), .req_ready_o(req_ready_o),
      .flush_i(flush_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_pc_o(rsp_pc_o),
      .rsp_instr_o(rsp_instr_o), .rsp_err_o(rsp_err_o),
      .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] load_val(input int i);
      return i == 0 ? 32'h123450B7 : i == 1 ? 32'h67808093 : i == 3 ? 32'h32110113 :
             32'h10000013 + 32'(i << 7);
   endfunction

   function automatic rsp_t expect_rsp(input logic [31:0] pc);
      rsp_t        r;
      int unsigned idx;
      idx     = (pc >> 2) % DEPTH;
      r.pc    = pc;
      r.err   = 1'b0;
      for (int k = 0; k < FW; k++) r.instr[32*k +: 32] = mdl[(idx + k) % DEPTH];
`ifdef IMEM_FAULT_CHECK_EN
      if (pc[1:0] != 2'b00 || (pc >> 2) + FW - 1 >= DEPTH) begin
         r.err   = 1'b1;
         r.instr = '0;
      end
`endif
      return r;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      req_valid_i = 1'b0;
      flush_i     = 1'b0;
      wr_en_i     = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) tick();
      repeat (LAT + 1) tick();
   endtask

   task automatic run_monitor();
      rsp_t e;
      forever begin
         @(negedge clk_i);
         if (!rstn_i) q.delete();
         else begin
            if (rsp_valid_o && rsp_ready_i) begin
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL sb_unexpected: got pc=%h instr=%h, none expected", rsp_pc_o, rsp_instr_o);
               end else begin
                  e = q.pop_front();
                  if ({rsp_pc_o, rsp_instr_o, rsp_err_o} !== e) begin
                     errors++;
                     $display("FAIL sb_rsp: got pc=%h instr=%h err=%b exp pc=%h instr=%h err=%b",
                              rsp_pc_o, rsp_instr_o, rsp_err_o, e.pc, e.instr, e.err);
                  end
               end
            end
            if (flush_i) q.delete();
            if (req_valid_i && req_ready_o) q.push_back(expect_rsp(req_pc_i));
            if (wr_en_i) mdl[wr_idx_i] = wr_data_i;
         end
      end
   endtask

   task automatic test_reset();
      #12;
      checks += 5;
      if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", rsp_valid_o); end
      if (rsp_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", rsp_pc_o); end
      if (rsp_instr_o !== '0) begin errors++; $display("FAIL reset_instr: got %h exp 0", rsp_instr_o); end
      if (rsp_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", rsp_err_o); end
      if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", req_ready_o); end
      tick();
      rstn_i = 1'b1;
   endtask

   task automatic test_load();
      for (int i = 0; i < DEPTH; i++) begin
         wr_en_i   = 1'b1;
         wr_idx_i  = AW'(i);
         wr_data_i = load_val(i);
         tick();
      end
      idle();
   endtask

   task automatic test_basic();
      rsp_ready_i = 1'b1;
      req_valid_i = 1'b1;
      req_pc_i    = 32'h0;
      tick();
      req_pc_i = 32'h4;
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early: got valid=%b exp 0", rsp_valid_o); end
      tick();
      idle();
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_pc_o !== 32'h0 || rsp_instr_o[31:0] !== 32'h123450B7) begin
         errors++;
         $display("FAIL basic_first: got v=%b pc=%h w0=%h exp v=1 pc=0 w0=123450b7", rsp_valid_o, rsp_pc_o, rsp_instr_o[31:0]);
      end
      tick();
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_pc_o !== 32'h4 || rsp_instr_o[31:0] !== 32'h67808093) begin
         errors++;
         $display("FAIL basic_second: got v=%b pc=%h w0=%h exp v=1 pc=4 w0=67808093", rsp_valid_o, rsp_pc_o, rsp_instr_o[31:0]);
      end
      tick();
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL basic_after: got valid=%b exp 0", rsp_valid_o); end
      wait_drain();
   endtask

   task automatic test_backpressure();
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b1;
      req_pc_i    = 32'h0;
      tick();
      req_pc_i = 32'h4;
      tick();
      req_pc_i = 32'h8;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         checks++;
         if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_pc_o !== 32'h0 ||
             rsp_instr_o[31:0] !== 32'h123450B7) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got rdy=%b v=%b pc=%h w0=%h exp rdy=0 v=1 pc=0 w0=123450b7",
                     i, req_ready_o, rsp_valid_o, rsp_pc_o, rsp_instr_o[31:0]);
         end
         tick();
      end
      rsp_ready_i = 1'b1;
      tick();
      idle();
      wait_drain();
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d pending exp 0", q.size()); end
   endtask

   task automatic test_flush();
      rsp_ready_i = 1'b1;
      req_valid_i = 1'b1;
      req_pc_i    = 32'h14;
      tick();
      req_pc_i = 32'h18;
      tick();
      rsp_ready_i = 1'b0;
      flush_i     = 1'b1;
      req_pc_i    = 32'h8;
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL flush_pre: got v=%b rdy=%b exp v=1 rdy=1", rsp_valid_o, req_ready_o);
      end
      tick();
      idle();
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL flush_kill: got valid=%b exp 0", rsp_valid_o); end
      tick();
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_pc_o !== 32'h8) begin
         errors++;
         $display("FAIL flush_new: got v=%b pc=%h exp v=1 pc=8", rsp_valid_o, rsp_pc_o);
      end
      tick();
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL flush_after: got valid=%b exp 0", rsp_valid_o); end
      wait_drain();
   endtask

   task automatic test_rbw();
      rsp_ready_i = 1'b1;
      wr_en_i     = 1'b1;
      wr_idx_i    = AW'(3);
      wr_data_i   = 32'hDEADBEEF;
      req_valid_i = 1'b1;
      req_pc_i    = 32'hC;
      tick();
      wr_en_i = 1'b0;
      tick();
      idle();
      @(negedge clk_i);
      checks++;
      if (rsp_instr_o[31:0] !== 32'h32110113) begin
         errors++;
         $display("FAIL rbw_old: got %h exp 32110113", rsp_instr_o[31:0]);
      end
      tick();
      @(negedge clk_i);
      checks++;
      if (rsp_instr_o[31:0] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rbw_new: got %h exp deadbeef", rsp_instr_o[31:0]);
      end
      wait_drain();
   endtask

   task automatic test_wrap();
      logic [63:0] exp_i;
      logic        exp_e;
`ifdef IMEM_FAULT_CHECK_EN
      exp_i = '0;
      exp_e = 1'b1;
`else
      exp_i = {load_val(0), load_val(15)};
      exp_e = 1'b0;
`endif
      req_valid_i = 1'b1;
      req_pc_i    = 32'h3C;
      tick();
      idle();
      tick();
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_pc_o !== 32'h3C || rsp_instr_o !== exp_i || rsp_err_o !== exp_e) begin
         errors++;
         $display("FAIL wrap: got v=%b pc=%h instr=%h err=%b exp v=1 pc=3c instr=%h err=%b",
                  rsp_valid_o, rsp_pc_o, rsp_instr_o, rsp_err_o, exp_i, exp_e);
      end
      wait_drain();
   endtask

   task automatic test_fault_reset();
      logic [63:0] exp_i;
      logic        exp_e;
`ifdef IMEM_FAULT_CHECK_EN
      exp_i = '0;
      exp_e = 1'b1;
`else
      exp_i = {load_val(1), load_val(0)};
      exp_e = 1'b0;
`endif
      req_valid_i = 1'b1;
      req_pc_i    = 32'h2;
      tick();
      idle();
      tick();
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_pc_o !== 32'h2 || rsp_instr_o !== exp_i || rsp_err_o !== exp_e) begin
         errors++;
         $display("FAIL fault_misalign: got v=%b pc=%h instr=%h err=%b exp v=1 pc=2 instr=%h err=%b",
                  rsp_valid_o, rsp_pc_o, rsp_instr_o, rsp_err_o, exp_i, exp_e);
      end
      wait_drain();
      req_valid_i = 1'b1;
      req_pc_i    = 32'h0;
      tick();
      req_pc_i = 32'h4;
      tick();
      req_pc_i = 32'h8;
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre: got valid=%b exp 1", rsp_valid_o); end
      #2;
      rstn_i = 1'b0;
      #1;
      checks += 5;
      if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b exp 0", rsp_valid_o); end
      if (rsp_pc_o !== 32'h0) begin errors++; $display("FAIL mid_pc: got %h exp 0", rsp_pc_o); end
      if (rsp_instr_o !== '0) begin errors++; $display("FAIL mid_instr: got %h exp 0", rsp_instr_o); end
      if (rsp_err_o !== 1'b0) begin errors++; $display("FAIL mid_err: got %b exp 0", rsp_err_o); end
      if (req_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b exp 1", req_ready_o); end
      idle();
      tick();
      tick();
      rstn_i      = 1'b1;
      req_valid_i = 1'b1;
      req_pc_i    = 32'h4;
      tick();
      idle();
      tick();
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_pc_o !== 32'h4 || rsp_instr_o[31:0] !== 32'h67808093) begin
         errors++;
         $display("FAIL post_reset: got v=%b pc=%h w0=%h exp v=1 pc=4 w0=67808093", rsp_valid_o, rsp_pc_o, rsp_instr_o[31:0]);
      end
      wait_drain();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++) begin
         req_valid_i = $urandom_range(0, 3) != 0;
         req_pc_i    = ($urandom_range(0, DEPTH - 1) << 2) | ($urandom_range(0, 7) == 0 ? 32'h1 : 32'h0);
         rsp_ready_i = $urandom_range(0, 3) != 0;
         wr_en_i     = $urandom_range(0, 3) == 0;
         wr_idx_i    = AW'($urandom_range(0, DEPTH - 1));
         wr_data_i   = $urandom;
         flush_i     = ($urandom_range(0, 15) == 0) && !(rsp_valid_o && rsp_ready_i);
         tick();
      end
      idle();
      rsp_ready_i = 1'b1;
      wait_drain();
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending exp 0", q.size()); end
   endtask

   initial begin
      fork
         run_monitor();
      join_none
      test_reset();
      test_load();
      test_basic();
      test_backpressure();
      test_flush();
      test_rbw();
      test_wrap();
      test_fault_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog expired");
   end
endmodule
